// File: rtl/seq_1011_tx.sv
// Serial 1011 pattern transmitter: shifts a parallel word out MSB-first on a valid/data strobe
// and counts the overlapping 1011 occurrences a downstream detector should report.
module seq_1011_tx #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned GAP_CYC = 1,
  parameter int unsigned CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             valid,
  output logic             data_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] exp_cnt
);

  localparam int unsigned IdxW = $clog2(WIDTH);
  localparam int unsigned GapW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [IdxW-1:0]  IdxLast = IdxW'(WIDTH - 1);
  localparam logic [GapW-1:0]  GapLast = GapW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  typedef enum logic [1:0] {StIdle, StShift, StGap, StDone} state_e;
  typedef enum logic [2:0] {TrkR, Trk1, Trk10, Trk101, Trk1011} trk_e;

  state_e           state_q, state_d;
  trk_e             trk_q, trk_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             data_q, data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cur_bit;
  logic             hit;

  assign cur_bit = shreg_q[WIDTH-1];

  always_comb begin
    state_d = state_q;
    trk_d   = trk_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    cnt_d   = cnt_q;
    hit     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StShift;
          shreg_d = din;
          cnt_d   = '0;
          trk_d   = TrkR;
          idx_d   = '0;
        end
      end
      StShift: begin
        case (trk_q)
          TrkR:    trk_d = cur_bit ? Trk1 : TrkR;
          Trk1:    trk_d = cur_bit ? Trk1 : Trk10;
          Trk10:   trk_d = cur_bit ? Trk101 : TrkR;
          Trk101: begin
            trk_d = cur_bit ? Trk1011 : Trk10;
            hit   = cur_bit;
          end
          Trk1011: trk_d = cur_bit ? Trk1 : Trk10;
          default: trk_d = TrkR;
        endcase
        if (hit && (cnt_q != CntMax)) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (idx_q == IdxLast) begin
          state_d = StDone;
        end else begin
          shreg_d = shreg_q << 1;
          idx_d   = idx_q + 1'b1;
          gap_d   = '0;
          state_d = (GAP_CYC == 0) ? StShift : StGap;
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          state_d = StShift;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are derived from the next state so they register alongside it.
    valid_d = (state_d == StShift);
    data_d  = valid_d & shreg_d[WIDTH-1];
    busy_d  = (state_d != StIdle);
    done_d  = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      trk_q   <= TrkR;
      shreg_q <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      trk_q   <= trk_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign valid    = valid_q;
  assign data_out = data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign exp_cnt  = cnt_q;

endmodule

// File: tb/tb_seq_1011_tx.sv
// Bench for seq_1011_tx: one instance with a 1-cycle gap and one back-to-back, checked against a
// word-level model of the serial timing and of the overlapping 1011 count.
module tb_seq_1011_tx;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start0, start1;
  logic [W-1:0] din0, din1;
  logic         v0, d0, b0, dn0, v1, d1, b1, dn1;
  logic [3:0]   c0, c1;
  logic         sel;
  logic         v, d, b, dn;
  logic [3:0]   c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_1011_tx #(.WIDTH(W), .GAP_CYC(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .din(din0), .valid(v0), .data_out(d0),
    .busy(b0), .done(dn0), .exp_cnt(c0)
  );

  seq_1011_tx #(.WIDTH(W), .GAP_CYC(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .din(din1), .valid(v1), .data_out(d1),
    .busy(b1), .done(dn1), .exp_cnt(c1)
  );

  assign v  = sel ? v1 : v0;
  assign d  = sel ? d1 : d0;
  assign b  = sel ? b1 : b0;
  assign dn = sel ? dn1 : dn0;
  assign c  = sel ? c1 : c0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Overlapping 1011 occurrences read MSB-first, saturated to the counter width.
  function automatic int unsigned ref_count(input logic [W-1:0] w);
    int unsigned n = 0;
    for (int i = 0; i <= W - 4; i++) begin
      if (((w >> i) & 8'h0F) == 8'h0B) n++;
    end
    return (n > 15) ? 15 : n;
  endfunction

  task automatic drive(input int gap, input logic s, input logic [W-1:0] w);
    if (gap == 1) begin
      start1 = s;
      din1   = w;
    end else begin
      start0 = s;
      din0   = w;
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 32'(v), 32'd0);
    check({tag, "_busy"}, 32'(b), 32'd0);
    check({tag, "_done"}, 32'(dn), 32'd0);
  endtask

  // Called at a negedge with the selected DUT idle; returns at the idle cycle after done.
  task automatic xmit(input int gap, input logic [W-1:0] word, input bit keep);
    int win;
    logic exp_v, exp_d;
    sel = (gap == 1);
    win = W + (W - 1) * gap;
    drive(gap, 1'b1, word);
    @(negedge clk);
    for (int k = 0; k < win; k++) begin
      exp_v = ((k % (gap + 1)) == 0);
      exp_d = exp_v ? word[W - 1 - k / (gap + 1)] : 1'b0;
      check("win_valid", 32'(v), 32'(exp_v));
      check("win_data", 32'(d), 32'(exp_d));
      check("win_busy", 32'(b), 32'd1);
      check("win_done", 32'(dn), 32'd0);
      drive(gap, keep ? 1'b1 : 1'($urandom_range(1)), W'($urandom));
      @(negedge clk);
    end
    check("done_pulse", 32'(dn), 32'd1);
    check("done_busy", 32'(b), 32'd1);
    check("done_valid", 32'(v), 32'd0);
    check("done_cnt", 32'(c), ref_count(word));
    drive(gap, keep ? 1'b1 : 1'($urandom_range(1)), W'($urandom));
    @(negedge clk);
    check_idle("after_done");
    check("hold_cnt", 32'(c), ref_count(word));
    drive(gap, keep, word);
  endtask

  // Reset asserted during the cycle showing bit number nbits (1-based).
  task automatic mid_reset(input int gap, input logic [W-1:0] word, input int nbits);
    sel = (gap == 1);
    drive(gap, 1'b1, word);
    @(negedge clk);
    drive(gap, 1'b0, word);
    for (int k = 0; k < (nbits - 1) * (gap + 1); k++) @(negedge clk);
    check("pre_rst_data", 32'(d), 32'(word[W - nbits]));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("mid_rst");
    check("mid_rst_cnt", 32'(c), 32'd0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("abandon_done", 32'(dn), 32'd0);
      check("abandon_valid", 32'(v), 32'd0);
    end
  endtask

  initial begin
    int gap;
    bit keep, prev_keep;
    logic [W-1:0] w;
    sel = 1'b0;
    rst = 1'b1;
    start0 = 1'b1;
    start1 = 1'b1;
    din0 = 8'hB6;
    din1 = 8'hB6;

    // Reset dominates a simultaneous start.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        sel = s[0];
        check_idle("reset");
        check("reset_cnt", 32'(c), 32'd0);
      end
    end
    rst = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    @(negedge clk);
    sel = 1'b1;
    check_idle("post_reset");

    xmit(1, 8'b10110110, 1'b0);
    check("dir_gap1_cnt", 32'(c), 32'd2);
    xmit(0, 8'b10111011, 1'b0);
    check("dir_gap0_cnt", 32'(c), 32'd2);
    xmit(0, 8'hFF, 1'b0);
    check("dir_ff_cnt", 32'(c), 32'd0);

    // Start held across two words.
    xmit(1, 8'b01011011, 1'b1);
    xmit(1, 8'b01011011, 1'b0);
    check("b2b_cnt", 32'(c), 32'd2);
    xmit(0, 8'b01011011, 1'b1);
    xmit(0, 8'b01011011, 1'b0);
    check("b2b0_cnt", 32'(c), 32'd2);

    mid_reset(1, 8'b10110110, 3);
    xmit(1, 8'b10110110, 1'b0);
    mid_reset(0, 8'b10110000, 5);
    xmit(0, 8'b10110000, 1'b0);

    prev_keep = 1'b0;
    gap = 0;
    for (int n = 0; n < 100; n++) begin
      if (!prev_keep) gap = int'($urandom_range(1));
      w = W'($urandom);
      keep = (n != 99) && ($urandom_range(3) == 0);
      xmit(gap, w, keep);
      prev_keep = keep;
    end
    start0 = 1'b0;
    start1 = 1'b0;
    @(negedge clk);
    check_idle("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
